// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci control FSM: state encoding, the datapath
// control-word bundle and the control word each state drives.
package fib_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_CHECK,
        ST_EXP_A,
        ST_EXP_B,
        ST_LEAF,
        ST_FIN,
        ST_ERR
    } state_e;

    typedef struct packed {
        logic push;
        logic pop;
        logic s;
        logic s1;
        logic ld;
        logic z_ans;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE  = '0;
    localparam ctrl_t CTRL_INIT  = '{push: 1'b1, pop: 1'b0, s: 1'b1, s1: 1'b0, ld: 1'b0, z_ans: 1'b1};
    localparam ctrl_t CTRL_EXP_A = '{push: 1'b1, pop: 1'b1, s: 1'b0, s1: 1'b0, ld: 1'b0, z_ans: 1'b0};
    localparam ctrl_t CTRL_EXP_B = '{push: 1'b1, pop: 1'b0, s: 1'b0, s1: 1'b0, ld: 1'b0, z_ans: 1'b0};
    localparam ctrl_t CTRL_LEAF  = '{push: 1'b0, pop: 1'b1, s: 1'b0, s1: 1'b0, ld: 1'b1, z_ans: 1'b0};

    // A full stack turns the second expansion push into a no-op on the way to ERR.
    function automatic ctrl_t ctrl_of(input state_e st, input logic at_max);
        ctrl_t c;
        case (st)
            ST_INIT:  c = CTRL_INIT;
            ST_EXP_A: c = CTRL_EXP_A;
            ST_EXP_B: c = at_max ? CTRL_NONE : CTRL_EXP_B;
            ST_LEAF:  c = CTRL_LEAF;
            default:  c = CTRL_NONE;
        endcase
        return c;
    endfunction

    function automatic logic is_busy_state(input state_e st);
        return (st == ST_INIT) || (st == ST_CHECK) || (st == ST_EXP_A) ||
               (st == ST_EXP_B) || (st == ST_LEAF);
    endfunction

endpackage

// File: rtl/fib_depth_counter.sv
// Mirrors the datapath stack occupancy so the controller can refuse a push
// that would exceed DEPTH entries; the count never wraps in either direction.
module fib_depth_counter
    import fib_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic at_max_o
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] MAX = DW'(DEPTH);

    logic [DW-1:0] depth_q;
    logic [DW-1:0] depth_d;

    // NOTE: depth_d is assigned first on every path so no latch is inferred.
    always_comb begin
        depth_d = clr_i ? '0 : depth_q;
        if (inc_i && (depth_d != MAX)) begin
            depth_d = depth_d + 1'b1;
        end else if (dec_i && (depth_d != '0)) begin
            depth_d = depth_d - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    assign at_max_o = (depth_q == MAX);

endmodule

// File: rtl/fib_controller.sv
// Moore control FSM for the recursive-Fibonacci datapath, with start/done
// handshake, sticky stack-overflow flag and a saturating busy-cycle counter.
module fib_controller
    import fib_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          G,
    input  logic          isEmpty,
    output logic          push,
    output logic          pop,
    output logic          s,
    output logic          s1,
    output logic          ld,
    output logic          z_ans,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] cycles
);

    localparam logic [CW-1:0] CYC_MAX = '1;

    state_e        state_q;
    state_e        state_d;
    ctrl_t         ctrl_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [CW-1:0] cycles_q;
    logic          at_max;

    fib_depth_counter #(
        .DEPTH (DEPTH)
    ) u_depth (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q == ST_INIT),
        .inc_i    ((state_q == ST_INIT) || (state_q == ST_EXP_B)),
        .dec_i    (state_q == ST_LEAF),
        .at_max_o (at_max)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_INIT;
            ST_INIT:  state_d = ST_CHECK;
            ST_CHECK: begin
                if (isEmpty)  state_d = ST_FIN;
                else if (G)   state_d = ST_EXP_A;
                else          state_d = ST_LEAF;
            end
            ST_EXP_A: state_d = ST_EXP_B;
            ST_EXP_B: state_d = at_max ? ST_ERR : ST_CHECK;
            ST_LEAF:  state_d = ST_CHECK;
            ST_FIN:   state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they always equal the
    // decode of the state currently held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: every control register is reset so the datapath sees idle
            // controls on the first cycle after reset.
            state_q  <= ST_IDLE;
            ctrl_q   <= CTRL_NONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_of(state_d, at_max);
            busy_q  <= is_busy_state(state_d);
            done_q  <= (state_d == ST_FIN) || (state_d == ST_ERR);

            if (state_d == ST_ERR) begin
                err_q <= 1'b1;
            end else if ((state_q == ST_IDLE) && start) begin
                err_q <= 1'b0;
            end

            if ((state_q == ST_IDLE) && start) begin
                cycles_q <= '0;
            end else if (is_busy_state(state_q) && (cycles_q != CYC_MAX)) begin
                cycles_q <= cycles_q + 1'b1;
            end
        end
    end

    assign push   = ctrl_q.push;
    assign pop    = ctrl_q.pop;
    assign s      = ctrl_q.s;
    assign s1     = ctrl_q.s1;
    assign ld     = ctrl_q.ld;
    assign z_ans  = ctrl_q.z_ans;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign cycles = cycles_q;

endmodule

// File: tb/tb_fib_controller.sv
// Scoreboard bench: two controllers (DEPTH 8 and 3) each drive a behavioural
// stack/accumulator datapath; expected results come from Fibonacci arithmetic.
module tb_fib_controller;

    localparam int DEPTH_A = 8;
    localparam int DEPTH_B = 3;
    localparam int CYC_SAT = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, start_b;
    logic       g_a, e_a, g_b, e_b;
    logic       push_a, pop_a, s_a, s1_a, ld_a, z_a, busy_a, done_a, err_a;
    logic       push_b, pop_b, s_b, s1_b, ld_b, z_b, busy_b, done_b, err_b;
    logic [7:0] cyc_a, cyc_b;

    int n_a, n_b;
    int stk_a [64];
    int stk_b [64];
    int sp_a, sp_b, acc_a, acc_b, top_a, top_b;

    fib_controller #(.DEPTH(DEPTH_A), .CW(8)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .G(g_a), .isEmpty(e_a),
        .push(push_a), .pop(pop_a), .s(s_a), .s1(s1_a), .ld(ld_a), .z_ans(z_a),
        .busy(busy_a), .done(done_a), .err(err_a), .cycles(cyc_a)
    );

    fib_controller #(.DEPTH(DEPTH_B), .CW(8)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .G(g_b), .isEmpty(e_b),
        .push(push_b), .pop(pop_b), .s(s_b), .s1(s1_b), .ld(ld_b), .z_ans(z_b),
        .busy(busy_b), .done(done_b), .err(err_b), .cycles(cyc_b)
    );

    // Behavioural datapaths: stack of integers plus a leaf-counting accumulator.
    always_comb begin
        top_a = (sp_a > 0) ? stk_a[sp_a-1] : 0;
        top_b = (sp_b > 0) ? stk_b[sp_b-1] : 0;
        g_a   = (sp_a > 0) && (top_a > 1);
        g_b   = (sp_b > 0) && (top_b > 1);
        e_a   = (sp_a == 0);
        e_b   = (sp_b == 0);
    end

    always @(posedge clk) begin
        if (!rst) begin
            sp_a  <= 0;
            acc_a <= 0;
        end else begin
            if (z_a)       acc_a <= 0;
            else if (ld_a) acc_a <= acc_a + 1;
            if (push_a && pop_a) begin
                stk_a[sp_a-1] <= s_a ? n_a : top_a - (s1_a ? 2 : 1);
            end else if (push_a) begin
                stk_a[sp_a] <= s_a ? n_a : top_a - (s1_a ? 2 : 1);
                sp_a        <= sp_a + 1;
            end else if (pop_a) begin
                sp_a <= sp_a - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            sp_b  <= 0;
            acc_b <= 0;
        end else begin
            if (z_b)       acc_b <= 0;
            else if (ld_b) acc_b <= acc_b + 1;
            if (push_b && pop_b) begin
                stk_b[sp_b-1] <= s_b ? n_b : top_b - (s1_b ? 2 : 1);
            end else if (push_b) begin
                stk_b[sp_b] <= s_b ? n_b : top_b - (s1_b ? 2 : 1);
                sp_b        <= sp_b + 1;
            end else if (pop_b) begin
                sp_b <= sp_b - 1;
            end
        end
    end

    // Reference model.
    function automatic int fib(input int k);
        int a, b, t;
        a = 0;
        b = 1;
        for (int i = 0; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Deepest stack of the walk: the n-2 subtree sits one slot above the n-1 entry.
    function automatic int peak_of(input int n);
        int p [16];
        p[0] = 1;
        p[1] = 1;
        for (int i = 2; i <= n; i++) p[i] = (p[i-1] > p[i-2] + 1) ? p[i-1] : p[i-2] + 1;
        return p[n];
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    typedef struct packed {
        int   inst;
        int   n;
        logic err;
        int   sout;
        int   cyc;
        int   bcnt;
        int   pk;
    } exp_t;

    exp_t       sb_q [$];
    logic [5:0] trace_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         done_seen = 0;
    int         ld_cnt [2];
    int         z_cnt [2];
    int         bcnt [2];
    int         pk [2];
    bit         s1_seen [2];
    bit         prev_done [2];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: accumulate per-run statistics and score each done pulse.
    task automatic observe(input int i, input logic [5:0] cw, input logic busy,
                           input logic done, input logic err, input logic [7:0] cyc,
                           input int acc, input int sp);
        exp_t e;
        if (cw[0]) begin
            ld_cnt[i]  = 0;
            z_cnt[i]   = 0;
            bcnt[i]    = 0;
            pk[i]      = 0;
            s1_seen[i] = 1'b0;
            if (i == 0) trace_q.delete();
        end
        if (busy) begin
            bcnt[i]++;
            if (i == 0) trace_q.push_back(cw);
        end
        z_cnt[i]  += int'(cw[0]);
        ld_cnt[i] += int'(cw[1]);
        if (cw[2]) s1_seen[i] = 1'b1;
        if (sp > pk[i]) pk[i] = sp;
        if (done) begin
            check("done_single_pulse", prev_done[i], 0);
            if (sb_q.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("done_instance", i, e.inst);
                check("err_at_done", err, e.err);
                check("busy_low_at_done", busy, 0);
                check("peak_depth", pk[i], e.pk);
                check("s1_never_high", s1_seen[i], 0);
                if (!e.err) begin
                    check("sout", acc, e.sout);
                    check("cycles", cyc, e.cyc);
                    check("busy_cycles", bcnt[i], e.bcnt);
                    check("ld_count", ld_cnt[i], e.sout);
                    check("z_ans_count", z_cnt[i], 1);
                end
            end
            done_seen++;
        end
        prev_done[i] = done;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            observe(0, {push_a, pop_a, s_a, s1_a, ld_a, z_a}, busy_a, done_a, err_a, cyc_a, acc_a, sp_a);
            observe(1, {push_b, pop_b, s_b, s1_b, ld_b, z_b}, busy_b, done_b, err_b, cyc_b, acc_b, sp_b);
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int i);
        if (i == 0) start_a = 1'b1; else start_b = 1'b1;
        tick(1);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
    endtask

    // Issue one run; when tracked, queue its expectation and wait for done.
    task automatic issue(input int i, input int n, input bit noise, input bit track);
        exp_t e;
        int   dp;
        int   target;
        int   k;
        dp = (i == 0) ? DEPTH_A : DEPTH_B;
        if (i == 0) n_a = n; else n_b = n;
        if (track) begin
            e.inst = i;
            e.n    = n;
            e.err  = peak_of(n) > dp;
            e.sout = fib(n + 1);
            e.bcnt = 5 * fib(n + 1) - 1;
            e.cyc  = imin(e.bcnt, CYC_SAT);
            e.pk   = imin(peak_of(n), dp);
            sb_q.push_back(e);
        end
        target = done_seen + 1;
        pulse_start(i);
        if (noise && n >= 3) begin
            tick(2);
            pulse_start(i);
        end
        if (track) begin
            k = 0;
            while (done_seen < target && k < 3000) begin
                tick(1);
                k++;
            end
            check("done_within_budget", done_seen >= target, 1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl_a"}, {push_a, pop_a, s_a, s1_a, ld_a, z_a, busy_a, done_a, err_a}, 0);
        check({tag, "_cycles_a"}, cyc_a, 0);
        check({tag, "_ctrl_b"}, {push_b, pop_b, s_b, s1_b, ld_b, z_b, busy_b, done_b, err_b}, 0);
        check({tag, "_cycles_b"}, cyc_b, 0);
    endtask

    initial begin
        logic [5:0] exp_tr [9];
        exp_tr = '{6'b101001, 6'b000000, 6'b110000, 6'b100000, 6'b000000,
                   6'b010010, 6'b000000, 6'b010010, 6'b000000};
        rst     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        n_a     = 0;
        n_b     = 0;
        tick(3);
        check_all_zero("reset");
        rst = 1'b1;
        tick(2);

        issue(0, 0, 1'b0, 1'b1);
        tick(1);
        issue(0, 2, 1'b0, 1'b1);
        check("trace_len_n2", trace_q.size(), 9);
        for (int j = 0; j < 9; j++) begin
            if (j < trace_q.size()) check($sformatf("trace_n2_%0d", j), trace_q[j], exp_tr[j]);
        end
        tick(2);
        issue(0, 7, 1'b0, 1'b1);

        // Back-to-back: the second start lands on the first IDLE cycle.
        issue(0, 3, 1'b0, 1'b1);
        issue(0, 4, 1'b0, 1'b1);
        tick(1);

        issue(0, 5, 1'b1, 1'b1);
        tick(1);

        issue(0, 5, 1'b0, 1'b0);
        tick(10);
        rst = 1'b0;
        tick(1);
        check_all_zero("midrun_reset");
        rst = 1'b1;
        tick(2);

        issue(0, 10, 1'b0, 1'b1);
        tick(1);

        issue(1, 7, 1'b0, 1'b1);
        tick(5);
        check("err_sticky_idle", err_b, 1);
        check("idle_after_err", {busy_b, done_b}, 0);
        issue(1, 2, 1'b0, 1'b0);
        check("err_cleared_by_start", err_b, 0);
        check("busy_in_init", busy_b, 1);
        pulse_reset();

        issue(1, 5, 1'b0, 1'b1);
        tick(1);
        issue(1, 6, 1'b0, 1'b1);
        pulse_reset();

        for (int r = 0; r < 14; r++) begin
            int inst;
            int n;
            bit nz;
            inst = int'($urandom_range(0, 1));
            n    = (inst == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 7));
            nz   = bit'($urandom_range(0, 1));
            tick(int'($urandom_range(0, 3)));
            issue(inst, n, nz, 1'b1);
            tick(1);
            if (inst == 1 && peak_of(n) > DEPTH_B) pulse_reset();
        end

        tick(5);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
